// File: rtl/counter_cmd_pkg.sv
// Shared constants for the command sequencer that drives a downstream 4-bit counter.
// Holds the opcode encoding, the IDLE/RUN state encoding and the datapath width.
package counter_cmd_pkg;

   localparam int W      = 4;
   localparam int STRB_W = 6;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;
   localparam logic [2:0] OP_RSV  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/counter_cmd_decode.sv
// Opcode decoder: one-hot strobe vector ordered {R,L,INC,DEC,SHL,SHR}, plus the reserved flag.
// NOP and the reserved opcode produce no strobe.
module counter_cmd_decode
   import counter_cmd_pkg::*;
(
   input  logic [2:0]        i_op,
   output logic [STRB_W-1:0] o_strb,
   output logic              o_rsv
);

   always_comb begin
      o_strb = '0;
      o_rsv  = 1'b0;
      case (i_op)
         OP_CLR:  o_strb = 6'b100000;
         OP_LOAD: o_strb = 6'b010000;
         OP_INC:  o_strb = 6'b001000;
         OP_DEC:  o_strb = 6'b000100;
         OP_SHL:  o_strb = 6'b000010;
         OP_SHR:  o_strb = 6'b000001;
         OP_RSV:  o_rsv  = 1'b1;
         default: o_strb = '0;
      endcase
   end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer: accepts {op, data, repeat} commands and replays the matching
// counter strobe REP+1 times on registered outputs, with back-to-back chaining and abort.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no command active; strobes, D, DONE and ERR are low
//   RUN   | replaying latched op; r_rem counts strobes still to follow
module counter_cmd_sequencer
   import counter_cmd_pkg::*;
(
   input  logic         C,
   input  logic         RN,
   input  logic         CMD_VALID,
   input  logic [2:0]   CMD_OP,
   input  logic [W-1:0] CMD_D,
   input  logic [W-1:0] CMD_REP,
   input  logic         ABORT,
   output logic         CMD_READY,
   output logic [W-1:0] D,
   output logic         R,
   output logic         L,
   output logic         INC,
   output logic         DEC,
   output logic         SHL,
   output logic         SHR,
   output logic         DONE,
   output logic         ERR
);

   state_e              r_state;
   logic [W-1:0]        r_rem;
   logic [2:0]          r_op;
   logic [W-1:0]        r_d_lat;
   logic [W-1:0]        r_d_out;
   logic [STRB_W-1:0]   r_strb;
   logic                r_done;
   logic                r_err;

   state_e              w_state_nxt;
   logic [W-1:0]        w_rem_nxt;
   logic [2:0]          w_op_nxt;
   logic [W-1:0]        w_d_nxt;
   logic [STRB_W-1:0]   w_dec_strb;
   logic                w_dec_rsv;
   logic                w_accept;
   logic                w_run_nxt;
   logic [STRB_W-1:0]   w_strb_nxt;
   logic [W-1:0]        w_dout_nxt;
   logic                w_done_nxt;
   logic                w_err_nxt;

   assign CMD_READY = ((r_state == ST_IDLE) || ((r_state == ST_RUN) && (r_rem == '0)))
                      && !ABORT && RN;
   assign w_accept  = CMD_VALID && CMD_READY;

   // Decode the op that will be active next cycle so the strobes come straight from flops.
   counter_cmd_decode u_decode (
      .i_op   (w_op_nxt),
      .o_strb (w_dec_strb),
      .o_rsv  (w_dec_rsv)
   );

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_op    <= OP_NOP;
         r_d_lat <= '0;
         r_d_out <= '0;
         r_strb  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_op    <= w_op_nxt;
         r_d_lat <= w_d_nxt;
         r_d_out <= w_dout_nxt;
         r_strb  <= w_strb_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_op_nxt    = r_op;
      w_d_nxt     = r_d_lat;
      if (ABORT) begin
         w_state_nxt = ST_IDLE;
         w_rem_nxt   = '0;
         w_op_nxt    = OP_NOP;
         w_d_nxt     = '0;
      end else if (w_accept) begin
         w_state_nxt = ST_RUN;
         w_rem_nxt   = CMD_REP;
         w_op_nxt    = CMD_OP;
         w_d_nxt     = CMD_D;
      end else if (r_state == ST_RUN) begin
         if (r_rem != '0) begin
            w_rem_nxt = r_rem - W'(1);
         end else begin
            w_state_nxt = ST_IDLE;
            w_op_nxt    = OP_NOP;
            w_d_nxt     = '0;
         end
      end
   end

   always_comb begin
      w_run_nxt  = (w_state_nxt == ST_RUN);
      w_strb_nxt = w_run_nxt ? w_dec_strb : '0;
      w_dout_nxt = w_run_nxt ? w_d_nxt : '0;
      w_done_nxt = w_run_nxt && (w_rem_nxt == '0);
      w_err_nxt  = w_accept && w_dec_rsv;
   end

   assign {R, L, INC, DEC, SHL, SHR} = r_strb;
   assign D    = r_d_out;
   assign DONE = r_done;
   assign ERR  = r_err;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: each task drives a scenario and checks
// the full output vector {strobes, D, DONE, ERR, CMD_READY} every cycle at the falling edge.
module tb_counter_cmd_sequencer;

   logic       C = 1'b0;
   logic       RN = 1'b0;
   logic       CMD_VALID = 1'b0;
   logic [2:0] CMD_OP = 3'd0;
   logic [3:0] CMD_D = 4'd0;
   logic [3:0] CMD_REP = 4'd0;
   logic       ABORT = 1'b0;
   logic       CMD_READY;
   logic [3:0] D;
   logic       R, L, INC, DEC, SHL, SHR, DONE, ERR;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_L    = 6'b010000;
   localparam logic [5:0] S_INC  = 6'b001000;
   localparam logic [5:0] S_DEC  = 6'b000100;
   localparam logic [5:0] S_SHL  = 6'b000010;
   localparam logic [5:0] S_SHR  = 6'b000001;

   counter_cmd_sequencer dut (
      .C         (C),
      .RN        (RN),
      .CMD_VALID (CMD_VALID),
      .CMD_OP    (CMD_OP),
      .CMD_D     (CMD_D),
      .CMD_REP   (CMD_REP),
      .ABORT     (ABORT),
      .CMD_READY (CMD_READY),
      .D         (D),
      .R         (R),
      .L         (L),
      .INC       (INC),
      .DEC       (DEC),
      .SHL       (SHL),
      .SHR       (SHR),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 C = ~C;

   wire [12:0] obs = {R, L, INC, DEC, SHL, SHR, D, DONE, ERR, CMD_READY};

   function automatic logic [12:0] ev(input logic [5:0] s, input logic [3:0] d,
                                      input logic done, input logic err, input logic rdy);
      return {s, d, done, err, rdy};
   endfunction

   // Caller sits at a falling edge; returns at the falling edge of the first RUN cycle.
   task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] rep);
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      CMD_D     = d;
      CMD_REP   = rep;
      @(posedge C);
      #1;
      CMD_VALID = 1'b0;
      CMD_OP    = 3'd0;
      CMD_D     = 4'd0;
      CMD_REP   = 4'd0;
      @(negedge C);
   endtask

   task automatic test_reset();
      logic [12:0] exp;
      #1;
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_async: got %b want %b", obs, exp);
      end
      @(negedge C);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_held: got %b want %b", obs, exp);
      end
      RN = 1'b1;
      #1;
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want %b", obs, exp);
      end
      @(negedge C);
   endtask

   task automatic test_load();
      logic [12:0] exp;
      issue(3'b001, 4'd9, 4'd0);
      exp = ev(S_L, 4'd9, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL load_c1: got %b want %b", obs, exp);
      end
      @(negedge C);
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL load_idle: got %b want %b", obs, exp);
      end
   endtask

   task automatic test_inc_rep3();
      logic [12:0] exp;
      issue(3'b010, 4'd0, 4'd3);
      for (int i = 1; i <= 5; i++) begin
         if (i <= 3)      exp = ev(S_INC, 4'd0, 1'b0, 1'b0, 1'b0);
         else if (i == 4) exp = ev(S_INC, 4'd0, 1'b1, 1'b0, 1'b1);
         else             exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
         n_chk++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL inc_rep3 cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge C);
      end
   endtask

   task automatic test_rep15();
      logic [12:0] exp;
      issue(3'b010, 4'd0, 4'd15);
      for (int i = 1; i <= 17; i++) begin
         if (i <= 15)      exp = ev(S_INC, 4'd0, 1'b0, 1'b0, 1'b0);
         else if (i == 16) exp = ev(S_INC, 4'd0, 1'b1, 1'b0, 1'b1);
         else              exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
         n_chk++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL rep15 cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge C);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] exp;
      issue(3'b011, 4'd0, 4'd1);
      exp = ev(S_DEC, 4'd0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL b2b_c1: got %b want %b", obs, exp);
      end
      @(negedge C);
      exp = ev(S_DEC, 4'd0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL b2b_c2: got %b want %b", obs, exp);
      end
      issue(3'b101, 4'd8, 4'd0);
      exp = ev(S_SHR, 4'd8, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL b2b_c3: got %b want %b", obs, exp);
      end
      @(negedge C);
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL b2b_idle: got %b want %b", obs, exp);
      end
   endtask

   task automatic test_abort();
      logic [12:0] exp;
      issue(3'b100, 4'd0, 4'd15);
      for (int i = 1; i <= 5; i++) begin
         exp = ev(S_SHL, 4'd0, 1'b0, 1'b0, 1'b0);
         n_chk++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL abort_shl cycle %0d: got %b want %b", i, obs, exp);
         end
         if (i < 5) @(negedge C);
      end
      // Abort together with an offered command: the command must not be taken.
      ABORT     = 1'b1;
      CMD_VALID = 1'b1;
      CMD_OP    = 3'b010;
      CMD_REP   = 4'd2;
      #1;
      n_chk++;
      if (CMD_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_ready_low: got %b want 0", CMD_READY);
      end
      @(posedge C);
      #1;
      ABORT     = 1'b0;
      CMD_VALID = 1'b0;
      CMD_OP    = 3'd0;
      CMD_REP   = 4'd0;
      @(negedge C);
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL abort_after: got %b want %b", obs, exp);
      end
      @(negedge C);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL abort_idle: got %b want %b", obs, exp);
      end
   endtask

   task automatic test_reserved();
      logic [12:0] exp;
      issue(3'b111, 4'd5, 4'd2);
      for (int i = 1; i <= 4; i++) begin
         case (i)
            1:       exp = ev(S_NONE, 4'd5, 1'b0, 1'b1, 1'b0);
            2:       exp = ev(S_NONE, 4'd5, 1'b0, 1'b0, 1'b0);
            3:       exp = ev(S_NONE, 4'd5, 1'b1, 1'b0, 1'b1);
            default: exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
         endcase
         n_chk++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reserved cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge C);
      end
   endtask

   task automatic test_reset_mid();
      logic [12:0] exp;
      issue(3'b010, 4'd0, 4'd7);
      @(negedge C);
      exp = ev(S_INC, 4'd0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL rstmid_run: got %b want %b", obs, exp);
      end
      #1;
      RN = 1'b0;
      #1;
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL rstmid_async_drop: got %b want %b", obs, exp);
      end
      #1;
      RN = 1'b1;
      @(negedge C);
      exp = ev(S_NONE, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL rstmid_after: got %b want %b", obs, exp);
      end
      issue(3'b011, 4'd3, 4'd0);
      exp = ev(S_DEC, 4'd3, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL rstmid_next_cmd: got %b want %b", obs, exp);
      end
      @(negedge C);
   endtask

   initial begin
      test_reset();
      test_load();
      test_inc_rep3();
      test_back_to_back();
      test_abort();
      test_reserved();
      test_rep15();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
